// File: rtl/revaluate_engine.sv
// Line revaluation engine: reads LINES lines from a memory file, optionally applies the
// column-parity (theta) transform, and writes the result back, all in one burst per start.
module revaluate_engine #(
    parameter int LINES = 64,
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    localparam int WIDTH = ROWS * COLS,
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [9:0]       file_index,
    output logic [9:0]       mem_sel,
    output logic             rd_en,
    output logic [LW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic             wr_en,
    output logic [LW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             finish
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } state_e;

    localparam logic [LW-1:0] LAST = LW'(LINES - 1);

    state_e         state_q, state_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           mode_q, mode_d;
    logic [9:0]     sel_q, sel_d;
    logic           rd_vld_q;
    logic [LW-1:0]  rd_addr_q;
    logic [WIDTH-1:0] line_buf_q [LINES];

    logic           last;
    logic [LW-1:0]  prev_idx;
    logic [WIDTH-1:0] cur_line, prev_line, theta;
    logic [COLS-1:0]  par_cur, par_prev;

    assign last = (cnt_q == LAST);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        busy    = 1'b1;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = READ;
                    cnt_d   = '0;
                    mode_d  = mode;
                    sel_d   = file_index;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            DRAIN: begin
                state_d = WRITE;
                cnt_d   = '0;
            end
            WRITE: begin
                wr_en = 1'b1;
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line 0 borrows parity from the last line; with a single line it uses its own.
    assign prev_idx  = (cnt_q == '0) ? LAST : cnt_q - LW'(1);
    assign cur_line  = line_buf_q[cnt_q];
    assign prev_line = line_buf_q[prev_idx];

    for (genvar x = 0; x < COLS; x++) begin : g_col
        logic [ROWS-1:0] col_cur, col_prev;
        for (genvar y = 0; y < ROWS; y++) begin : g_row
            assign col_cur[y]  = cur_line[y*COLS + x];
            assign col_prev[y] = prev_line[y*COLS + x];
            assign theta[y*COLS + x] = cur_line[y*COLS + x]
                                     ^ par_cur[(x + COLS - 1) % COLS]
                                     ^ par_prev[(x + 1) % COLS];
        end
        assign par_cur[x]  = ^col_cur;
        assign par_prev[x] = ^col_prev;
    end

    assign mem_sel = sel_q;
    assign rd_addr = rd_en ? cnt_q : '0;
    assign wr_addr = wr_en ? cnt_q : '0;
    assign wr_data = wr_en ? (mode_q ? theta : cur_line) : '0;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            sel_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            rd_vld_q  <= rd_en;
            rd_addr_q <= rd_addr;
        end
    end

    // NOTE: the line buffer has no reset; every entry is rewritten before it is read in a run.
    always_ff @(posedge clk) begin
        if (rd_vld_q) line_buf_q[rd_addr_q] <= rd_data;
    end

endmodule

// File: doc/revaluate_engine.md
REVALUATE_ENGINE -- requirements
Module: revaluate_engine

Interface
REQ-001 Parameter LINES, default 64: number of lines (slices) per state; legal range 1..1024.
REQ-002 Parameter ROWS, default 5: rows per line.
REQ-003 Parameter COLS, default 5: columns per line; WIDTH = ROWS*COLS; LW = max(1, clog2(LINES)).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 mode  in  1  0 = copy, 1 = theta transform; latched when start is accepted.
REQ-008 file_index  in  10  memory/file selector; latched when start is accepted.
REQ-009 mem_sel  out  10  latched file_index, driven for both read and write traffic.
REQ-010 rd_en  out  1  read strobe; rd_data is valid exactly one cycle after rd_en.
REQ-011 rd_addr  out  LW  line index of the read.
REQ-012 rd_data  in  WIDTH  line data returned by memory.
REQ-013 wr_en  out  1  write strobe.
REQ-014 wr_addr  out  LW  line index of the write.
REQ-015 wr_data  out  WIDTH  transformed line.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 finish  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, READ, DRAIN, WRITE, DONE.
REQ-019 IDLE -> READ on start=1; latch mode and file_index; clear line counter.
REQ-020 READ lasts LINES cycles: rd_en=1, rd_addr = counter 0..LINES-1 ascending.
REQ-021 Each rd_data is captured into internal buffer entry (rd_addr of the previous cycle).
REQ-022 DRAIN lasts 1 cycle and captures the final line; rd_en=0.
REQ-023 WRITE lasts LINES cycles: wr_en=1, wr_addr = counter 0..LINES-1 ascending, wr_data = f(buffer).
REQ-024 DONE lasts 1 cycle with finish=1, then the FSM returns to IDLE.
REQ-025 Latency: if start is sampled at edge 0, finish is high in cycle 2*LINES+2; the engine accepts the next start in the following cycle.
REQ-026 Bit (x,y) of a line is at bit index y*COLS+x, with x in 0..COLS-1 and y in 0..ROWS-1.
REQ-027 Copy mode: wr_data = buffer[i].
REQ-028 Theta mode: C_i[x] = XOR over y of line i bit (x,y); out bit (x,y) = in(x,y) ^ C_i[(x-1) mod COLS] ^ C_p[(x+1) mod COLS], where p = (i-1) mod LINES.
REQ-029 Wrap-around: line 0 uses line LINES-1 as p; when LINES=1, p = i (the line uses its own parity).
REQ-030 start while busy=1 is ignored, and mode and file_index changes while busy have no effect.
REQ-031 Outside READ, rd_en=0; outside WRITE, wr_en=0. rd_addr and wr_addr hold 0 when not strobed.
REQ-032 The buffer is never read for output before all LINES entries of the current run are captured.

Reset
REQ-033 rst_n=0 forces state IDLE immediately, regardless of clock.
REQ-034 Reset values: busy=0, finish=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, mem_sel=0, counter=0, latched mode=0.
REQ-035 Reset mid-operation aborts the run: no further rd_en or wr_en pulses, and finish is not asserted. Buffer contents need not be cleared.
REQ-036 After rst_n deasserts, the first start is accepted at the next rising edge.

Verification
REQ-037 Defaults, mode=1, all lines 0 -> 64 writes of 0x0000000, addresses 0..63 ascending; finish in cycle 130; busy high in cycles 1..130.
REQ-038 Defaults, mode=1, line0=0x0000001, other lines 0 -> line0 out=0x0210843, line1 out=0x1084210, all other lines 0.
REQ-039 mode=0, line i = i*0x0012345 truncated to 25 bits -> written data identical to read data; file_index=0x2A3 appears on mem_sel throughout.
REQ-040 start pulsed again in cycle 10 of a run with different file_index -> ignored; exactly 64 writes; mem_sel keeps its original value.
REQ-041 rst_n pulled low in WRITE cycle 20 -> outputs reach their reset values asynchronously, and no writes or finish follow; a new start then completes a full run normally.
REQ-042 LINES=1, ROWS=COLS=5, mode=1, line0=0x0000001 -> one write of 0x1294A53 (self-wrap parity); finish in cycle 4.
